// File: rtl/gray_ptr_counter.sv
// Up/down pointer counter with a registered Gray-code copy, lap bit and limit flags.
// Intended for FIFO pointers: gray and lap feed the opposite clock domain.
module gray_ptr_counter #(
  parameter int WIDTH    = 6,
  parameter int MAX      = 63,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             lap,
  output logic             at_min,
  output logic             at_max,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic             lap_q,   lap_d;
  logic             at_min_q, at_min_d;
  logic             at_max_q, at_max_d;
  logic             wrap_q,  wrap_d;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    lap_d   = lap_q;
    wrap_d  = 1'b0;

    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q < MAX_V) begin
          count_d = count_q + WIDTH'(1);
        end else if (!SATURATE) begin
          count_d = '0;
          lap_d   = ~lap_q;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else if (!SATURATE) begin
          count_d = MAX_V;
          lap_d   = ~lap_q;
          wrap_d  = 1'b1;
        end
      end
    end

    // Gray and flags derive from the next count so they land on the same edge as count.
    gray_d   = count_d ^ (count_d >> 1);
    at_min_d = (count_d == '0);
    at_max_d = (count_d == MAX_V);
  end

  // NOTE: clear is sampled only at the clock edge, so it stays out of the sensitivity list;
  // non-blocking assignments keep all registers updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!clear) begin
      count_q  <= '0;
      gray_q   <= '0;
      lap_q    <= 1'b0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      gray_q   <= gray_d;
      lap_q    <= lap_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count  = count_q;
  assign gray   = gray_q;
  assign lap    = lap_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Bench for gray_ptr_counter: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_gray_ptr_counter;

  localparam int W = 6;
  localparam int MX  [3] = '{63, 39, 39};
  localparam bit SAT [3] = '{1'b0, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         clear = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt [3];
  logic [W-1:0] gry [3];
  logic         lap_o [3];
  logic         amin [3];
  logic         amax [3];
  logic         wrp [3];

  int mc [3] = '{0, 0, 0};
  int ml [3] = '{0, 0, 0};
  int mw [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gray_ptr_counter #(.WIDTH(W), .MAX(63), .SATURATE(1'b0)) u0 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[0]), .gray(gry[0]), .lap(lap_o[0]), .at_min(amin[0]), .at_max(amax[0]), .wrap(wrp[0]));

  gray_ptr_counter #(.WIDTH(W), .MAX(39), .SATURATE(1'b0)) u1 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[1]), .gray(gry[1]), .lap(lap_o[1]), .at_min(amin[1]), .at_max(amax[1]), .wrap(wrp[1]));

  gray_ptr_counter #(.WIDTH(W), .MAX(39), .SATURATE(1'b1)) u2 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[2]), .gray(gry[2]), .lap(lap_o[2]), .at_min(amin[2]), .at_max(amax[2]), .wrap(wrp[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: count lives on the ring 0..MAX; stepping past an end either wraps or sticks.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      mw[i] = 0;
      if (!clear) begin
        mc[i] = 0;
        ml[i] = 0;
      end else if (load) begin
        mc[i] = (int'(load_val) < MX[i]) ? int'(load_val) : MX[i];
      end else if (en) begin
        if (up) begin
          if (mc[i] < MX[i]) mc[i] = mc[i] + 1;
          else if (!SAT[i]) begin mc[i] = 0; ml[i] = 1 - ml[i]; mw[i] = 1; end
        end else begin
          if (mc[i] > 0) mc[i] = mc[i] - 1;
          else if (!SAT[i]) begin mc[i] = MX[i]; ml[i] = 1 - ml[i]; mw[i] = 1; end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.count", i),  int'(cnt[i]),  mc[i]);
      check($sformatf("u%0d.gray", i),   int'(gry[i]),  mc[i] ^ (mc[i] / 2));
      check($sformatf("u%0d.lap", i),    int'(lap_o[i]), ml[i]);
      check($sformatf("u%0d.at_min", i), int'(amin[i]), (mc[i] == 0) ? 1 : 0);
      check($sformatf("u%0d.at_max", i), int'(amax[i]), (mc[i] == MX[i]) ? 1 : 0);
      check($sformatf("u%0d.wrap", i),   int'(wrp[i]),  mw[i]);
    end
  endtask

  task automatic cyc(input logic c, input logic l, input int lv, input logic e, input logic u);
    logic [W-1:0] pg;
    clear = c; load = l; load_val = lv[W-1:0]; en = e; up = u;
    pg = gry[0];
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (c && !l && e) check("u0.gray_step", $countones(gry[0] ^ pg), 1);
  endtask

  initial begin
    #2;
    // Reset state
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("rst.count", int'(cnt[0]), 0);
    check("rst.at_min", int'(amin[0]), 1);
    check("rst.wrap", int'(wrp[0]), 0);

    // Full lap on the default configuration
    for (int k = 0; k < 64; k++) cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
    check("lap64.count", int'(cnt[0]), 0);
    check("lap64.wrap", int'(wrp[0]), 1);
    check("lap64.lap", int'(lap_o[0]), 1);

    // MAX=39 wrap after load
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 38, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
    check("m39.count39", int'(cnt[1]), 39);
    check("m39.at_max", int'(amax[1]), 1);
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
    check("m39.count0", int'(cnt[1]), 0);
    check("m39.wrap", int'(wrp[1]), 1);
    check("m39.lap", int'(lap_o[1]), 1);

    // Saturating counter held at 0 while counting down
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("sat.count", int'(cnt[2]), 0);
      check("sat.at_min", int'(amin[2]), 1);
      check("sat.wrap", int'(wrp[2]), 0);
      check("sat.lap", int'(lap_o[2]), 0);
    end
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
    check("sat.up", int'(cnt[2]), 1);

    // Load above MAX clamps
    cyc(1'b1, 1'b1, 50, 1'b0, 1'b0);
    check("clamp.count", int'(cnt[1]), 39);
    check("clamp.at_max", int'(amax[1]), 1);
    check("clamp.gray", int'(gry[1]), 'b110100);
    check("noclamp.count", int'(cnt[0]), 50);

    // Clear beats load/en, and swallows a simultaneous wrap
    cyc(1'b0, 1'b1, 5, 1'b1, 1'b1);
    check("clrpri.count", int'(cnt[0]), 0);
    check("clrpri.lap", int'(lap_o[0]), 0);
    cyc(1'b1, 1'b1, 63, 1'b0, 1'b0);
    check("pre.count", int'(cnt[0]), 63);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
    check("clrwrap.count", int'(cnt[0]), 0);
    check("clrwrap.wrap", int'(wrp[0]), 0);
    check("clrwrap.lap", int'(lap_o[0]), 0);
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1);
    check("resume.count", int'(cnt[0]), 1);

    // Random traffic
    for (int k = 0; k < 10000; k++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_ptr_counter.md
GRAY_PTR_COUNTER -- requirements
Module: gray_ptr_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6, counter width in bits; legal range 2..16.
REQ-002 SHALL have parameter MAX, default 63, terminal count value; legal range 1..2^WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port clear  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port count  output  WIDTH  registered binary count.
REQ-011 SHALL have port gray  output  WIDTH  registered Gray code of count.
REQ-012 SHALL have port lap  output  1  registered wrap-parity bit, for FIFO full/empty disambiguation.
REQ-013 SHALL have port at_min  output  1  registered flag: count == 0.
REQ-014 SHALL have port at_max  output  1  registered flag: count == MAX.
REQ-015 SHALL have port wrap  output  1  registered one-cycle pulse marking a wrap.

Function
REQ-016 SHALL apply this priority each edge: clear low, then load, then en, then hold.
REQ-017 SHALL, on load, set count to min(load_val, MAX), leave lap unchanged, and drive wrap 0.
REQ-018 SHALL, on en with up=1 and count<MAX, set count to count+1.
REQ-019 SHALL, on en with up=0 and count>0, set count to count-1.
REQ-020 SHALL, with SATURATE=0, on en with up=1 and count==MAX, set count to 0, toggle lap, and drive wrap 1 for the next cycle only.
REQ-021 SHALL, with SATURATE=0, on en with up=0 and count==0, set count to MAX, toggle lap, and drive wrap 1 for the next cycle only.
REQ-022 SHALL, with SATURATE=1, hold count and lap at either limit under further enabled counting in that direction, and drive wrap 0.
REQ-023 SHALL, with en=0 and load=0, hold count, gray, lap, at_min and at_max, and drive wrap 0.
REQ-024 SHALL, in every cycle, keep gray == count XOR (count >> 1); both register on the same edge, with no cycle skew.
REQ-025 SHALL, in every cycle, keep at_min and at_max consistent with the current count; they are registered from next-state values, not decoded combinationally from count.
REQ-026 SHALL register wrap, so that wrap is 1 in exactly the cycle in which count first shows the wrapped value.
REQ-027 SHALL keep count, at every step, in the range 0..MAX; it never takes a value above MAX.
REQ-028 SHALL make gray change in exactly one bit on every enabled ±1 step where MAX = 2^WIDTH-1, including the wrap step.
REQ-029 SHALL NOT gate clk with en or any other signal; en acts as a synchronous data enable only.

Reset
REQ-030 SHALL, on a rising edge with clear=0, set count=0, gray=0, lap=0, at_min=1, at_max=0 and wrap=0.
REQ-031 SHALL give clear=0 priority over simultaneous load and en.
REQ-032 SHALL, when clear is asserted mid-count or in the same edge as a wrap, discard the pending wrap pulse and lap toggle.
REQ-033 SHALL resume counting from 0 on the first edge after clear returns high with en=1.

Verification
REQ-034 SHALL cover: defaults, clear low one cycle, then en=1 up=1 for 64 cycles -> count 0..63, then 0; wrap=1 only in the cycle count=0 after 63; lap=1; gray single-bit steps throughout.
REQ-035 SHALL cover: MAX=39, SATURATE=0, load load_val=38, then en up for 2 cycles -> count 39, then 0; at_max=1 at 39; wrap pulse in the cycle count=0; lap toggles.
REQ-036 SHALL cover: MAX=39, SATURATE=1, count at 0, en=1 up=0 for 3 cycles -> count stays 0, at_min=1, wrap=0, lap unchanged; then up=1 -> count 1.
REQ-037 SHALL cover: load load_val=50 with MAX=39 -> count=39, at_max=1, gray=6'b110100.
REQ-038 SHALL cover: clear=0 together with load=1, load_val=5, en=1 -> count=0, lap=0, wrap=0; then a clear asserted in the same edge as a 63 -> 0 wrap -> no wrap pulse, lap=0.
REQ-039 SHALL cover: random en/up/load sequences over 10k cycles -> scoreboard match on count, gray, lap and flags every cycle.
